// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, accumulator sizing and output conversion for matrix_mult_param.
// MATMUL_SAT_EN selects unsigned saturation instead of truncation on the row-write path.
package matmul_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // Works on a 64-bit carrier so one function serves every OW/ACC_W pairing.
    function automatic logic [63:0] out_conv(input logic [63:0] v, input int ow);
        logic [63:0] m;
        m = (64'd1 << ow) - 64'd1;
`ifdef MATMUL_SAT_EN
        return v > m ? m : v;
`else
        return v & m;
`endif
    endfunction
endpackage

// File: rtl/matmul_mac_lane.sv
// matmul_mac_lane: one column multiply-accumulate lane; clr wins over en.
module matmul_mac_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic             clr,
    input  logic             en,
    output logic [ACC_W-1:0] acc
);
    always_ff @(posedge clk)
        acc <= clr ? '0 : en ? acc + ACC_W'(a) * ACC_W'(b) : acc;
endmodule

// File: rtl/matrix_mult_param.sv
// matrix_mult_param: N x N unsigned matrix multiply, one output row per N cycles over N MAC lanes.
// Output conversion is truncation by default, unsigned saturation with MATMUL_SAT_EN.
module matrix_mult_param
    import matmul_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int OW = 8
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              Enable,
    input  logic [N*N*DW-1:0] A,
    input  logic [N*N*DW-1:0] B,
    output logic [N*N*OW-1:0] C,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W = acc_width(N, DW);
    localparam int IW    = $clog2(N);

    state_t              state;
    logic [IW-1:0]       i, k;
    logic [N*N*DW-1:0]   a_reg, b_reg;
    logic [DW-1:0]       a_ik;
    logic [ACC_W-1:0]    acc [N];
    logic [N*OW-1:0]     row_val;
    logic                start, run, last_k, last_i, clr;

    assign start  = state == IDLE && Enable;
    assign run    = state == COMPUTE;
    assign last_k = k == IW'(N - 1);
    assign last_i = i == IW'(N - 1);
    assign clr    = !reset || start || (run && last_k);
    assign a_ik   = a_reg[(i * N + k) * DW +: DW];

    // The row value folds in the final product directly, so lanes can clear on the same edge.
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [DW-1:0]    b_kj;
        logic [ACC_W-1:0] sum;
        logic [63:0]      cv;
        assign b_kj = b_reg[(k * N + j) * DW +: DW];
        assign sum  = acc[j] + ACC_W'(a_ik) * ACC_W'(b_kj);
        assign cv   = out_conv(64'(sum), OW);
        assign row_val[j * OW +: OW] = cv[OW-1:0];
        matmul_mac_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
            .clk(Clock),
            .a  (a_ik),
            .b  (b_kj),
            .clr(clr),
            .en (run),
            .acc(acc[j])
        );
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            C     <= '0;
        end else begin
            case (state)
                IDLE: if (Enable) begin
                    a_reg <= A;
                    b_reg <= B;
                    i     <= '0;
                    k     <= '0;
                    busy  <= 1'b1;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    k <= last_k ? '0 : k + 1'b1;
                    if (last_k) begin
                        C[i * N * OW +: N * OW] <= row_val;
                        i <= i + 1'b1;
                        if (last_i) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: if (!Enable) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_mult_param.sv
// tb_matrix_mult_param: table-driven and randomized checks of matrix_mult_param against a plain-arithmetic model.
// Covers MATMUL_SAT_EN in both builds through the model's conversion rule.
module tb_matrix_mult_param;
    localparam int W   = 512;
    localparam int WI4 = 128;
    localparam int WO4 = 320;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    logic           Clock = 0;
    logic           reset = 0;
    logic           Enable = 0;
    logic [W-1:0]   A = '0, B = '0, C;
    logic           busy, done;
    logic           en_w = 0;
    logic [WI4-1:0] a_w = '0, b_w = '0;
    logic [WO4-1:0] c_w;
    logic           busy_w, done_w;

    int vectors = 0;
    int miscompares = 0;

    matrix_mult_param u_dut (
        .Clock(Clock), .reset(reset), .Enable(Enable),
        .A(A), .B(B), .C(C), .busy(busy), .done(done)
    );

    matrix_mult_param #(.N(4), .DW(8), .OW(20)) u_wide (
        .Clock(Clock), .reset(reset), .Enable(en_w),
        .A(a_w), .B(b_w), .C(c_w), .busy(busy_w), .done(done_w)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_mat();
        logic [W-1:0] r;
        for (int n = 0; n < W / 32; n++) r[n*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: textbook triple loop, then the output rule of the selected build.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += int'(a[(i*8+k)*8 +: 8]) * int'(b[(k*8+j)*8 +: 8]);
`ifdef MATMUL_SAT_EN
                r[(i*8+j)*8 +: 8] = s > 255 ? 8'd255 : 8'(s);
`else
                r[(i*8+j)*8 +: 8] = 8'(s % 256);
`endif
            end
        return r;
    endfunction

    // Starts a run, scrambles the operand inputs mid-compute, reports cycles to done and busy count.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                       output int lat, output int bcnt);
        @(negedge Clock);
        A = a; B = b; Enable = 1;
        @(posedge Clock); #1;
        bcnt = busy ? 1 : 0;
        lat = 0;
        if (!hold) Enable = 0;
        for (int c = 1; c <= 200 && lat == 0; c++) begin
            @(posedge Clock); #1;
            if (c == 5) begin A = rand_mat(); B = rand_mat(); end
            if (done) lat = c;
            else if (busy) bcnt++;
        end
    endtask

    vec_t tbl[6];
    int lat, bcnt;
    logic [W-1:0] ra, rb;
    logic [WO4-1:0] exp_w;

    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                tbl[0].a[(i*8+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
                tbl[0].b[(i*8+j)*8 +: 8] = 8'(i * 8 + j);
                tbl[0].exp[(i*8+j)*8 +: 8] = 8'(i * 8 + j);
                tbl[1].a[(i*8+j)*8 +: 8] = 8'd255;
                tbl[1].b[(i*8+j)*8 +: 8] = 8'd255;
`ifdef MATMUL_SAT_EN
                tbl[1].exp[(i*8+j)*8 +: 8] = 8'd255;
`else
                tbl[1].exp[(i*8+j)*8 +: 8] = 8'd8;
`endif
            end
        for (int n = 2; n < 6; n++) begin
            tbl[n].a = rand_mat();
            tbl[n].b = rand_mat();
            if (n == 3) tbl[n].a = tbl[n].a & {64{8'h0f}};
            tbl[n].exp = model(tbl[n].a, tbl[n].b);
        end

        repeat (2) @(posedge Clock);
        #1;
        chk("reset_c", C, '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        @(negedge Clock); reset = 1;

        for (int n = 0; n < 6; n++) begin
            run(tbl[n].a, tbl[n].b, 1, lat, bcnt);
            chk($sformatf("vec%0d_c", n), C, tbl[n].exp);
            chk($sformatf("vec%0d_latency", n), W'(lat), W'(64));
            chk($sformatf("vec%0d_busy_cycles", n), W'(bcnt), W'(64));
            if (n == 0) begin
                repeat (10) @(posedge Clock);
                #1;
                chk("hold_done", W'(done), W'(1));
                chk("hold_busy", W'(busy), '0);
                chk("hold_c", C, tbl[0].exp);
            end
            @(negedge Clock); Enable = 0;
            @(posedge Clock); #1;
            chk($sformatf("vec%0d_done_fall", n), W'(done), '0);
        end

        // Mid-compute reset, then rerun with the same operands.
        ra = rand_mat(); rb = rand_mat();
        @(negedge Clock); A = ra; B = rb; Enable = 1;
        @(posedge Clock); #1; Enable = 0;
        repeat (20) @(posedge Clock);
        @(negedge Clock); reset = 0;
        @(posedge Clock); #1;
        chk("midrst_c", C, '0);
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        @(negedge Clock); reset = 1;
        run(ra, rb, 1, lat, bcnt);
        chk("midrst_rerun_c", C, model(ra, rb));
        chk("midrst_rerun_latency", W'(lat), W'(64));
        @(negedge Clock); Enable = 0;
        @(posedge Clock);

        // One-cycle Enable pulse: full result, one-cycle done, no restart.
        ra = rand_mat(); rb = rand_mat();
        run(ra, rb, 0, lat, bcnt);
        chk("pulse_c", C, model(ra, rb));
        chk("pulse_latency", W'(lat), W'(64));
        @(posedge Clock); #1;
        chk("pulse_done_one_cycle", W'(done), '0);
        repeat (3) @(posedge Clock);
        #1;
        chk("pulse_idle_busy", W'(busy), '0);
        chk("pulse_c_persist", C, model(ra, rb));

        // Wide output instance: N=4, OW=20.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_w[(i*4+j)*8 +: 8] = 8'(i + 1);
                b_w[(i*4+j)*8 +: 8] = 8'(j + 1);
                exp_w[(i*4+j)*20 +: 20] = 20'(4 * (i + 1) * (j + 1));
            end
        @(negedge Clock); en_w = 1;
        @(posedge Clock); #1; en_w = 0;
        lat = 0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(posedge Clock); #1;
            if (done_w) lat = c;
        end
        chk("wide_latency", W'(lat), W'(16));
        chk("wide_c", W'(c_w), W'(exp_w));
        chk("wide_c33", W'(c_w[15*20 +: 20]), W'(64));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_mult_param.md
# matrix_mult_param

Parametrised successor to the fixed 8×8, 8-bit matrix multiplier. It computes C = A·B for N×N unsigned matrices of DW-bit elements and produces OW-bit result elements, using N parallel multiply-accumulate lanes. It sits in the image-processing datapath behind the pixel/coefficient buffers and keeps the existing flat-bus and Enable/done handshake, so current benches and top levels port over directly.

## Interface
- N, default 8: matrix dimension; legal range 2..16.
- DW, default 8: input element width.
- OW, default 8: output element width; legal range 1..ACC_W.
- ACC_W, derived as 2*DW + clog2(N): accumulator width. Not user-overridable.
- Clock  in  1  sole clock; everything is rising-edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Enable  in  1  start request and level handshake.
- A  in  N*N*DW  element (i,j) at bits [(i*N+j)*DW +: DW].
- B  in  N*N*DW  same layout as A.
- C  out  N*N*OW  element (i,j) at bits [(i*N+j)*OW +: OW].
- busy  out  1  high in COMPUTE.
- done  out  1  result valid; high in DONE.

## Operation
- States: IDLE, COMPUTE, DONE.
- **IDLE:** when Enable=1, latch A and B into internal registers, clear row index i and inner index k, clear the accumulators, and go to COMPUTE.
- **COMPUTE, each cycle:** for every lane j in 0..N-1, acc[j] += Areg[i][k]*Breg[k][j], with k++.
  - When k=N-1, write row i of C from acc[j] + product, clear acc, set k=0, i++.
  - After row N-1 is written, go to DONE.
- **DONE:** done=1 and C is held stable. Stay in DONE while Enable=1; go to IDLE on the first cycle Enable=0.
- **Input changes:** A, B and Enable changes during COMPUTE are ignored, because the operands were latched at start.
- **Arithmetic:** products are DW×DW→2DW and accumulation is at ACC_W, so no overflow is possible internally. The output conversion is set by the Configuration macro.
- **Reset:** reset=0 in any state, including mid-COMPUTE, forces IDLE. It clears C, acc, i, k, busy and done on that same edge. Any partial result is discarded.
- **C persistence:** C keeps the last result through IDLE until the next row write or a reset.

## Timing
- **Reset values:** C=0, busy=0, done=0, state IDLE.
- **Start:** Enable is sampled high at edge t0. busy=1 from t0 through t0+N*N. done=1 from edge t0+N*N; for N=8 that is 64 cycles after t0.
- **Row write timing:** row i of C updates at edge t0+(i+1)*N.
- **Handshake, Enable held high:** done stays high indefinitely and no restart occurs.
- **Handshake, Enable low:** done falls on the edge after Enable is sampled low.
- **Back-to-back runs:** a new start requires at least one IDLE cycle, with Enable re-sampled high in IDLE.
- **Enable low before completion:** done still asserts for exactly one cycle, then the block returns to IDLE.

## Configuration
- **MATMUL_SAT_EN defined:** each output element is min(acc, 2^OW-1), i.e. unsigned saturation.
- **MATMUL_SAT_EN undefined:** each output element is acc[OW-1:0], i.e. truncation, matching the legacy block.
- The macro affects only the row-write path; latency is identical in both builds.

## Structure
- **Package matmul_pkg** holds:
  - the state encoding: IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2;
  - the ACC_W computation function;
  - the sat/trunc conversion function, guarded by MATMUL_SAT_EN.
- **Sub-module matmul_mac_lane** (one per column, generated N times):
  - inputs: a, b, clr, en;
  - output: acc of width ACC_W, held in a register;
  - clr has priority over en.
- **Top level** holds the FSM, the operand registers, the i/k counters, the row-write logic for C, and the generate loop of lanes.

## Test plan
- **Identity:** N=8, DW=8, OW=8; A=identity, B(i,j)=i*8+j. Expect C==B, done asserted exactly 64 cycles after start, busy high for 64 cycles.
- **Overflow:** N=8, DW=8, OW=8; all elements of A and B are 255, so the true result is 520200. Expect C=8 everywhere without MATMUL_SAT_EN and C=255 everywhere with it.
- **Wide output:** N=4, DW=8, OW=20; A(i,j)=i+1, B(i,j)=j+1. Expect C(i,j)=4*(i+1)*(j+1), e.g. C(3,3)=64; done at 16 cycles.
- **Mid-operation reset:** start, then drive reset=0 for one cycle at cycle 20. Expect C=0, done=0 and busy=0 on the next edge. Then restart with identical operands and expect a correct result at 64 cycles.
- **Handshake:**
  - Hold Enable high for 10 cycles after done: done stays high and C is unchanged.
  - Drop Enable: done falls on the next edge.
  - Change A, B during COMPUTE: the result uses the latched operands.
- **Short Enable pulse:** raise Enable for one cycle only. Expect the full computation, done high for exactly 1 cycle, then IDLE.
